issue_scheduler: RTL and testbench

- Issue scheduler for the Tomasulo back end.
- Each cycle it selects at most one instruction to issue from four issue queues: INT, LS, MUL and DIV. The chosen queue receives a one-hot `issueblk_done` pulse.
- It reserves the common data bus (CDB) slot in which the chosen unit's result will write back, so two units never collide on the CDB.
- It tracks occupancy of the non-pipelined divider.
- It sits between the `issueque_ready` outputs of the per-unit issue queues and the functional units / CDB mux.

---
 rtl/issue_pkg.sv | 35 +++
 rtl/issue_scheduler_if.sv | 29 ++
 rtl/cdb_reservation_shreg.sv | 52 +++++
 rtl/issue_scheduler.sv | 133 +++++++++++++
 tb/tb_issue_scheduler.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_pkg.sv
// +----------------------------------------------------------------------+
// | issue_pkg -- shared unit indices and latencies for the issue path    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package issue_pkg;

  localparam int NUM_IQ        = 4;
  localparam int IQ_W          = 2;
  localparam int LAT_INT       = 1;
  localparam int LAT_LS        = 2;
  localparam int LAT_MUL       = 4;
  localparam int LAT_DIV       = 6;
  localparam int DEF_RES_DEPTH = 8;

  typedef enum logic [IQ_W-1:0] {
    IQ_INT = 2'd0,
    IQ_LS  = 2'd1,
    IQ_MUL = 2'd2,
    IQ_DIV = 2'd3
  } iq_idx_e;

  function automatic int lat_of(input iq_idx_e idx);
    case (idx)
      IQ_INT:  return LAT_INT;
      IQ_LS:   return LAT_LS;
      IQ_MUL:  return LAT_MUL;
      default: return LAT_DIV;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/issue_scheduler_if.sv
// +----------------------------------------------------------------------+
// | issue_scheduler_if -- queue-ready / grant / CDB-owner bundle         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface issue_scheduler_if;
  import issue_pkg::*;

  logic [NUM_IQ-1:0] issueque_ready;
  logic              issue_stall;
  logic [NUM_IQ-1:0] issueblk_done;
  logic [IQ_W-1:0]   cdb_owner;
  logic              cdb_owner_valid;
  logic              div_busy;

  modport master (
    output issueque_ready, issue_stall,
    input  issueblk_done, cdb_owner, cdb_owner_valid, div_busy
  );

  modport slave (
    input  issueque_ready, issue_stall,
    output issueblk_done, cdb_owner, cdb_owner_valid, div_busy
  );

endinterface

`default_nettype wire

// File: rtl/cdb_reservation_shreg.sv
// +----------------------------------------------------------------------+
// | cdb_reservation_shreg -- CDB slot busy/owner shift register          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module cdb_reservation_shreg
  import issue_pkg::*;
#(
  parameter int DEPTH  = DEF_RES_DEPTH,
  parameter int SLOT_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [SLOT_W-1:0] set_slot,
  input  logic [IQ_W-1:0]   set_owner,
  output logic [DEPTH-1:0]  res,
  output logic [IQ_W-1:0]   owner0,
  output logic              valid0
);

  logic [DEPTH-1:0][IQ_W-1:0] owner;
  logic [DEPTH-1:0][IQ_W-1:0] owner_next;
  logic [DEPTH-1:0]           res_next;

  // Slot i holds the owner of the CDB i cycles from now; everything ages by one.
  always_comb begin
    res_next   = {1'b0, res[DEPTH-1:1]};
    owner_next = {IQ_W'(0), owner[DEPTH-1:1]};
    if (set_en) begin
      res_next[set_slot]   = 1'b1;
      owner_next[set_slot] = set_owner;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      res   <= '0;
      owner <= '0;
    end else begin
      res   <= res_next;
      owner <= owner_next;
    end
  end

  assign valid0 = res[0];
  assign owner0 = owner[0];

endmodule

`default_nettype wire

// File: rtl/issue_scheduler.sv
// +----------------------------------------------------------------------+
// | issue_scheduler -- one-per-cycle issue with CDB slot reservation;    |
// | ISSUE_FIXED_PRIO_EN selects DIV>MUL>LS>INT instead of round-robin.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module issue_scheduler
  import issue_pkg::*;
#(
  parameter int NUM_Q     = NUM_IQ,
  parameter int INT_LAT   = LAT_INT,
  parameter int LS_LAT    = LAT_LS,
  parameter int MUL_LAT   = LAT_MUL,
  parameter int DIV_LAT   = LAT_DIV,
  parameter int RES_DEPTH = DEF_RES_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  issue_scheduler_if.slave bus
);

  localparam int SLOT_W = $clog2(RES_DEPTH);
  localparam int DIV_W  = $clog2(DIV_LAT);
  localparam int LAT [NUM_Q] = '{INT_LAT, LS_LAT, MUL_LAT, DIV_LAT};

  if (NUM_Q != 4 || RES_DEPTH <= INT_LAT || RES_DEPTH <= LS_LAT ||
      RES_DEPTH <= MUL_LAT || RES_DEPTH <= DIV_LAT) begin : g_cfg_check
    $error("issue_scheduler: RES_DEPTH must exceed every unit latency");
  end

  logic [RES_DEPTH-1:0] res;
  logic [IQ_W-1:0]      owner0;
  logic                 valid0;
  logic [NUM_Q-1:0]     slot_taken;
  logic [NUM_Q-1:0]     elig;
  logic [NUM_Q-1:0]     grant;
  logic [IQ_W-1:0]      gidx;
  logic                 gvalid;
  logic [SLOT_W-1:0]    set_slot;
  logic [DIV_W-1:0]     div_cnt;

  // res[LAT] becomes res[LAT-1] after this edge, which is where a new grant would land.
  always_comb begin
    slot_taken = '0;
    for (int k = 0; k < NUM_Q; k++) begin
      slot_taken[k] = res[LAT[k]];
    end
  end

  for (genvar q = 0; q < NUM_Q; q++) begin : g_elig
    assign elig[q] = bus.issueque_ready[q] && !bus.issue_stall && !slot_taken[q] &&
                     ((q != int'(IQ_DIV)) || (div_cnt == '0));
  end

`ifdef ISSUE_FIXED_PRIO_EN
  always_comb begin
    grant  = '0;
    gidx   = '0;
    gvalid = 1'b0;
    for (int k = NUM_Q - 1; k >= 0; k--) begin
      if (!gvalid && elig[k]) begin
        grant[k] = 1'b1;
        gidx     = IQ_W'(k);
        gvalid   = 1'b1;
      end
    end
  end
`else
  logic [IQ_W-1:0] rr_ptr;
  logic [IQ_W-1:0] cand;

  // Ineligible queues are simply skipped, so a blocked slot never stalls the rest.
  always_comb begin
    grant  = '0;
    gidx   = '0;
    gvalid = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_Q; k++) begin
      cand = rr_ptr + IQ_W'(k);
      if (!gvalid && elig[cand]) begin
        grant[cand] = 1'b1;
        gidx        = cand;
        gvalid      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (gvalid) begin
      rr_ptr <= gidx + IQ_W'(1);
    end
  end
`endif

  always_comb begin
    set_slot = SLOT_W'(LAT[gidx] - 1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (grant[IQ_DIV]) begin
      div_cnt <= DIV_W'(DIV_LAT - 1);
    end else if (div_cnt != '0) begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  cdb_reservation_shreg #(
    .DEPTH  (RES_DEPTH),
    .SLOT_W (SLOT_W)
  ) u_res (
    .clk       (clk),
    .reset     (reset),
    .set_en    (gvalid),
    .set_slot  (set_slot),
    .set_owner (gidx),
    .res       (res),
    .owner0    (owner0),
    .valid0    (valid0)
  );

  assign bus.issueblk_done   = grant;
  assign bus.cdb_owner_valid = valid0;
  assign bus.cdb_owner       = valid0 ? owner0 : '0;
  assign bus.div_busy        = (div_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_issue_scheduler.sv
// +----------------------------------------------------------------------+
// | tb_issue_scheduler -- scoreboard bench for issue_scheduler           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_issue_scheduler;
  import issue_pkg::*;

  typedef struct {
    int         due;
    logic [1:0] own;
  } sb_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  sb_t  sb[$];

  issue_scheduler_if bus();

  issue_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  a_grant_onehot: assert property (@(posedge clk) $onehot0(bus.issueblk_done))
    else $error("issueblk_done not one-hot");

  // Sample one cycle, check grant and CDB against the scoreboard, then advance.
  task automatic tick(input logic [3:0] exp_grant, input string tag);
    int         hit;
    int         due;
    logic [1:0] qi;
    hit = -1;
    qi  = '0;
    #1;
    checks++;
    if (bus.issueblk_done !== exp_grant) begin
      failures++;
      $display("FAIL %s_grant cyc=%0d got=%b exp=%b", tag, cyc, bus.issueblk_done, exp_grant);
    end
    foreach (sb[i]) if (sb[i].due == cyc) hit = i;
    checks++;
    if (hit >= 0) begin
      if (bus.cdb_owner_valid !== 1'b1 || bus.cdb_owner !== sb[hit].own) begin
        failures++;
        $display("FAIL %s_cdb cyc=%0d got valid=%b owner=%0d exp valid=1 owner=%0d",
                 tag, cyc, bus.cdb_owner_valid, bus.cdb_owner, sb[hit].own);
      end
      sb.delete(hit);
    end else if (bus.cdb_owner_valid !== 1'b0 || bus.cdb_owner !== 2'd0) begin
      failures++;
      $display("FAIL %s_cdb cyc=%0d got valid=%b owner=%0d exp valid=0 owner=0",
               tag, cyc, bus.cdb_owner_valid, bus.cdb_owner);
    end
    // An observed grant must never land on a slot that is already owned.
    if (bus.issueblk_done != 4'b0) begin
      for (int i = 0; i < 4; i++) if (bus.issueblk_done[i]) qi = 2'(i);
      due = cyc + lat_of(iq_idx_e'(qi));
      checks++;
      foreach (sb[i]) begin
        if (sb[i].due == due) begin
          failures++;
          $display("FAIL %s_double_owner cyc=%0d slot=%0d got owners=%0d,%0d exp one",
                   tag, cyc, due, sb[i].own, qi);
        end
      end
    end
    if (exp_grant != 4'b0) begin
      for (int i = 0; i < 4; i++) if (exp_grant[i]) qi = 2'(i);
      sb.push_back('{due: cyc + lat_of(iq_idx_e'(qi)), own: qi});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    bus.issueque_ready = 4'b0;
    bus.issue_stall    = 1'b0;
    reset              = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc   = 0;
    sb.delete();
  endtask

  task automatic check_busy(input logic exp, input string tag);
    checks++;
    if (bus.div_busy !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got div_busy=%b exp=%b", tag, cyc, bus.div_busy, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks += 4;
    if (bus.issueblk_done !== 4'b0) begin
      failures++; $display("FAIL rst_grant got=%b exp=0000", bus.issueblk_done);
    end
    if (bus.cdb_owner_valid !== 1'b0) begin
      failures++; $display("FAIL rst_valid got=%b exp=0", bus.cdb_owner_valid);
    end
    if (bus.cdb_owner !== 2'd0) begin
      failures++; $display("FAIL rst_owner got=%0d exp=0", bus.cdb_owner);
    end
    if (bus.div_busy !== 1'b0) begin
      failures++; $display("FAIL rst_div_busy got=%b exp=0", bus.div_busy);
    end
  endtask

  task automatic test_single_int();
    do_reset();
    repeat (2) tick(4'b0000, "int_idle");
    bus.issueque_ready = 4'b0001;
    tick(4'b0001, "int_issue");
    bus.issueque_ready = 4'b0000;
    repeat (2) tick(4'b0000, "int_wb");
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [12] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0001, 4'b0010, 4'b0100, 4'b0001,
                                 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    do_reset();
    bus.issueque_ready = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      if (i == 7) check_busy(1'b1, "rr_div_busy_c7");
      if (i == 9) check_busy(1'b0, "rr_div_free_c9");
      tick(exp_seq[i], "rr");
    end
    bus.issueque_ready = 4'b0000;
    repeat (5) tick(4'b0000, "rr_drain");
  endtask

  task automatic test_conflict();
    do_reset();
    repeat (10) tick(4'b0000, "cf_idle");
    bus.issueque_ready = 4'b0100;
    tick(4'b0100, "cf_mul");
    bus.issueque_ready = 4'b0000;
    repeat (2) tick(4'b0000, "cf_gap");
    bus.issueque_ready = 4'b0001;
    tick(4'b0000, "cf_int_denied");
    tick(4'b0001, "cf_int_granted");
    bus.issueque_ready = 4'b0000;
    repeat (2) tick(4'b0000, "cf_drain");
  endtask

  task automatic test_div();
    do_reset();
    repeat (5) tick(4'b0000, "div_idle");
    bus.issueque_ready = 4'b1000;
    tick(4'b1000, "div_first");
    for (int i = 6; i <= 10; i++) begin
      check_busy(1'b1, "div_busy");
      tick(4'b0000, "div_blocked");
    end
    check_busy(1'b0, "div_free_c11");
    tick(4'b1000, "div_second");
    bus.issueque_ready = 4'b0000;
    repeat (7) tick(4'b0000, "div_drain");
  endtask

  task automatic test_stall();
    do_reset();
    repeat (17) tick(4'b0000, "st_idle");
    bus.issueque_ready = 4'b0100;
    tick(4'b0100, "st_mul");
    bus.issueque_ready = 4'b1000;
    tick(4'b1000, "st_div");
    bus.issueque_ready = 4'b0001;
    tick(4'b0001, "st_int");
    bus.issueque_ready = 4'b1111;
    bus.issue_stall    = 1'b1;
    repeat (2) tick(4'b0000, "st_hold");
    check_busy(1'b1, "st_div_busy_c22");
    tick(4'b0000, "st_hold");
    bus.issue_stall = 1'b0;
    tick(4'b0010, "st_resume_ls");
    check_busy(1'b0, "st_div_free_c24");
    tick(4'b0100, "st_resume_mul");
    bus.issueque_ready = 4'b0000;
    repeat (5) tick(4'b0000, "st_drain");
  endtask

  task automatic test_reset_midop();
    do_reset();
    bus.issueque_ready = 4'b0100;
    tick(4'b0100, "mr_mul");
    bus.issueque_ready = 4'b1000;
    tick(4'b1000, "mr_div");
    bus.issueque_ready = 4'b0000;
    check_busy(1'b1, "mr_div_busy");
    tick(4'b0000, "mr_idle");
    reset = 1'b0;
    tick(4'b0000, "mr_reset");
    sb.delete();
    reset = 1'b1;
    for (int i = 4; i <= 8; i++) begin
      check_busy(1'b0, "mr_div_cleared");
      tick(4'b0000, "mr_after");
    end
    bus.issueque_ready = 4'b1000;
    tick(4'b1000, "mr_div_again");
    bus.issueque_ready = 4'b0000;
    repeat (7) tick(4'b0000, "mr_drain");
  endtask

  initial begin
    bus.issueque_ready = 4'b0;
    bus.issue_stall    = 1'b0;
    test_reset();
    test_single_int();
    test_round_robin();
    test_conflict();
    test_div();
    test_stall();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
